// File: rtl/trng_word_sampler.sv
// Ring-oscillator TRNG word sampler: synchronises NCH entropy channels, XOR-combines
// them per sample tick and packs bits into words on a valid/ready port; holds the bias VDAC code.
// Build option VON_NEUMANN_EN inserts a von Neumann debiaser between the tick and the packer.
module trng_word_sampler #(
    parameter int NCH        = 4,
    parameter int BITWIDTH   = 8,
    parameter int SAMPLE_DIV = 4,
    parameter int DAC_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [NCH-1:0]      osc_in,
    input  logic                dac_load,
    input  logic [DAC_BITS-1:0] dac_wdata,
    output logic [DAC_BITS-1:0] dac_code,
    output logic [BITWIDTH-1:0] word_out,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                overrun
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(BITWIDTH);

    logic [NCH-1:0]      s1;
    logic [NCH-1:0]      s2;
    logic                raw;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic                accept;
    logic                accept_bit;
    logic [BITWIDTH-2:0] acc;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BITWIDTH-1:0] new_word;
    logic                word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
        end
    end

    assign raw  = ^s2;
    assign tick = ena && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (ena) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

`ifdef VON_NEUMANN_EN
    // state  | meaning
    // PAIR_A | waiting for the first bit of a pair
    // PAIR_B | first bit latched in pair_a, waiting for the second
    typedef enum logic {
        PAIR_A = 1'b0,
        PAIR_B = 1'b1
    } pair_t;

    pair_t pair_state;
    pair_t pair_next;
    logic  pair_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_state <= PAIR_A;
            pair_a     <= 1'b0;
        end else begin
            pair_state <= pair_next;
            if (tick && pair_state == PAIR_A) begin
                pair_a <= raw;
            end
        end
    end

    always_comb begin
        pair_next = pair_state;
        if (!ena) begin
            pair_next = PAIR_A;
        end else if (tick) begin
            pair_next = (pair_state == PAIR_A) ? PAIR_B : PAIR_A;
        end
    end

    always_comb begin
        accept     = 1'b0;
        accept_bit = pair_a;
        if (tick && pair_state == PAIR_B && raw != pair_a) begin
            accept = 1'b1;
        end
    end
`else
    assign accept     = tick;
    assign accept_bit = raw;
`endif

    assign new_word  = {acc, accept_bit};
    assign word_done = accept && (bit_cnt == CNT_W'(BITWIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            acc     <= new_word[BITWIDTH-2:0];
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

    // A finished word is only dropped when the previous one is neither empty nor leaving.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (word_done) begin
            if (!word_valid || word_ready) begin
                word_out   <= new_word;
                word_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code <= '0;
        end else if (dac_load) begin
            dac_code <= dac_wdata;
        end
    end

endmodule

// File: tb/tb_trng_word_sampler.sv
// Bench for trng_word_sampler: directed word scenarios plus random traffic, all checked
// against a cycle-level behavioural model (bit queue + enabled-cycle count).
module tb_trng_word_sampler;

    localparam int NCH        = 4;
    localparam int BITWIDTH   = 8;
    localparam int SAMPLE_DIV = 3;
    localparam int DAC_BITS   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ena = 1'b0;
    logic [NCH-1:0]      osc_in = '0;
    logic                dac_load = 1'b0;
    logic [DAC_BITS-1:0] dac_wdata = '0;
    logic [DAC_BITS-1:0] dac_code;
    logic [BITWIDTH-1:0] word_out;
    logic                word_valid;
    logic                word_ready = 1'b0;
    logic                overrun;

    int n_checks = 0;
    int n_errors = 0;

    trng_word_sampler #(
        .NCH(NCH), .BITWIDTH(BITWIDTH), .SAMPLE_DIV(SAMPLE_DIV), .DAC_BITS(DAC_BITS)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_in),
        .dac_load(dac_load), .dac_wdata(dac_wdata), .dac_code(dac_code),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: raw is the parity of osc_in seen two edges earlier, a tick is
    // every SAMPLE_DIV-th enabled cycle, accepted bits queue up and form a word MSB-first.
    logic [NCH-1:0]      m_h1, m_h2;
    int                  m_en_cnt;
    bit                  m_have_a, m_a;
    bit                  m_bits[$];
    logic [BITWIDTH-1:0] m_word, m_w;
    bit                  m_valid, m_over, m_live;
    logic [DAC_BITS-1:0] m_dac;
    bit                  m_raw, m_tick, m_got, m_b, m_done;

    initial begin
        m_live = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_h1 = '0; m_h2 = '0; m_en_cnt = 0; m_have_a = 0; m_a = 0;
            m_bits.delete();
            m_word = '0; m_valid = 0; m_over = 0; m_dac = '0; m_live = 1;
        end else begin
            m_raw  = ^m_h2;
            m_tick = ena && (m_en_cnt % SAMPLE_DIV == SAMPLE_DIV - 1);
            if (ena) m_en_cnt++;
            m_got = 0;
            m_b   = 0;
`ifdef VON_NEUMANN_EN
            if (!ena) begin
                m_have_a = 0;
            end else if (m_tick) begin
                if (!m_have_a) begin
                    m_a = m_raw;
                    m_have_a = 1;
                end else begin
                    m_have_a = 0;
                    if (m_raw != m_a) begin
                        m_got = 1;
                        m_b = m_a;
                    end
                end
            end
`else
            if (m_tick) begin
                m_got = 1;
                m_b = m_raw;
            end
`endif
            m_done = 0;
            if (m_got) begin
                m_bits.push_back(m_b);
                if (m_bits.size() == BITWIDTH) begin
                    m_done = 1;
                    m_w = '0;
                    foreach (m_bits[i]) m_w = (m_w << 1) | BITWIDTH'(m_bits[i]);
                    m_bits.delete();
                end
            end
            if (m_done) begin
                if (!m_valid || word_ready) begin
                    m_word = m_w;
                    m_valid = 1;
                end else begin
                    m_over = 1;
                end
            end else if (m_valid && word_ready) begin
                m_valid = 0;
            end
            if (dac_load) m_dac = dac_wdata;
            m_h2 = m_h1;
            m_h1 = osc_in;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_valid", word_valid, m_valid);
            check("model_word", word_out, m_word);
            check("model_overrun", overrun, m_over);
            check("model_dac", dac_code, m_dac);
        end
    end

    // Random channel pattern whose parity is b.
    function automatic logic [NCH-1:0] osc_for(input bit b);
        logic [NCH-1:0] v;
        v = NCH'($urandom);
        v[0] = b ^ (^v[NCH-1:1]);
        return v;
    endfunction

    // Feed the top nbits of w, MSB first, one raw value per sample window (two raw
    // values per bit with the debiaser). Optionally raise word_ready on the final edge.
    task automatic drive_word(input logic [BITWIDTH-1:0] w, input int nbits, input bit rdy_end);
        bit seq[$];
        seq.delete();
        for (int i = BITWIDTH - 1; i >= BITWIDTH - nbits; i--) begin
`ifdef VON_NEUMANN_EN
            seq.push_back(w[i]);
            seq.push_back(!w[i]);
`else
            seq.push_back(w[i]);
`endif
        end
        ena = 1'b1;
        foreach (seq[k]) begin
            osc_in = osc_for(seq[k]);
            for (int c = 0; c < SAMPLE_DIV; c++) begin
                if (rdy_end && k == seq.size() - 1 && c == SAMPLE_DIV - 1) word_ready = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        ena = 1'b0;
        word_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", word_valid, 0);
        check("reset_word", word_out, 0);
        check("reset_overrun", overrun, 0);
        check("reset_dac", dac_code, 0);

        dac_wdata = 8'hA5;
        dac_load  = 1'b1;
        @(posedge clk);
        #1;
        dac_load = 1'b0;
        @(negedge clk);
        check("dac_load_no_ena", dac_code, 8'hA5);

        drive_word(8'hFF, BITWIDTH, 0);
        @(negedge clk);
        check("ones_valid", word_valid, 1);
        check("ones_word", word_out, 8'hFF);

        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        @(negedge clk);
        check("consume_valid", word_valid, 0);
        check("consume_word_kept", word_out, 8'hFF);

        drive_word(8'h00, BITWIDTH, 0);
        @(negedge clk);
        check("zeros_word", word_out, 8'h00);

        drive_word(8'h5A, BITWIDTH, 1);
        @(negedge clk);
        check("swap_valid", word_valid, 1);
        check("swap_word", word_out, 8'h5A);
        check("swap_no_overrun", overrun, 0);

        drive_word(8'hC3, BITWIDTH, 0);
        @(negedge clk);
        check("drop_word_held", word_out, 8'h5A);
        check("drop_overrun", overrun, 1);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        @(negedge clk);
        check("drop_valid_fall", word_valid, 0);
        check("drop_overrun_sticky", overrun, 1);

        drive_word(8'hB7, 5, 0);
        pulse_rst();
        @(negedge clk);
        check("midrst_valid", word_valid, 0);
        check("midrst_word", word_out, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_dac", dac_code, 0);
        drive_word(8'h96, BITWIDTH, 0);
        @(negedge clk);
        check("after_rst_word", word_out, 8'h96);
        check("after_rst_valid", word_valid, 1);

`ifdef VON_NEUMANN_EN
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        ena = 1'b1;
        osc_in = osc_for(1'b1);
        repeat (BITWIDTH * 2 * SAMPLE_DIV + 4) @(posedge clk);
        #1;
        ena = 1'b0;
        @(negedge clk);
        check("vn_constant_no_word", word_valid, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            ena        = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) osc_in = NCH'($urandom);
            word_ready = ($urandom_range(0, 2) != 0);
            dac_load   = ($urandom_range(0, 9) == 0);
            dac_wdata  = DAC_BITS'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        ena = 1'b0;
        dac_load = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
